seven_segment_display_arbiter: RTL and testbench

Shares the 4-digit seven-segment display among NUM_REQ requesters using a request/grant handshake. Arbitration is round-robin with a minimum dwell time per owner. Sits between the value sources (counters, status registers) and the seven-segment display controller. Outputs the owner's BCD word plus a per-digit blank mask, which the controller multiplexes onto the anodes.

---
 rtl/seven_segment_pkg.sv | 34 +++
 rtl/seven_segment_display_arbiter_round_robin_picker.sv | 36 +++
 rtl/seven_segment_display_arbiter.sv | 150 +++++++++++++++
 tb/tb_seven_segment_display_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types, constants and blanking helpers for the seven-segment display arbiter.
package seven_segment_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } arbiter_state_t;

    localparam int DIGITS = 4;
    localparam int BCD_W  = 4;
    localparam logic [DIGITS-1:0] BLANK_ALL = 4'hF;

    // A digit above 9 is not valid BCD and must not reach the segment decoder.
    function automatic logic [DIGITS-1:0] invalid_mask(input logic [DIGITS*BCD_W-1:0] value);
        logic [DIGITS-1:0] mask;
        mask = '0;
        for (int d = 0; d < DIGITS; d++) begin
            mask[d] = (value[d*BCD_W +: BCD_W] > 4'd9);
        end
        return mask;
    endfunction

    // Zero digits that precede the first non-zero digit; the ones digit always shows.
    function automatic logic [DIGITS-1:0] leading_zero_mask(input logic [DIGITS*BCD_W-1:0] value);
        logic [DIGITS-1:0] mask;
        mask    = '0;
        mask[3] = (value[15:12] == 4'd0);
        mask[2] = mask[3] && (value[11:8] == 4'd0);
        mask[1] = mask[2] && (value[7:4] == 4'd0);
        return mask;
    endfunction

endpackage

// File: rtl/seven_segment_display_arbiter_round_robin_picker.sv
// Combinational round-robin pick: first requester found searching upward from last_owner+1.
module round_robin_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx
);

    logic found;
    int   cand;

    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = 0;
        // Offset NUM_REQ wraps back to last_owner, so it wins only when alone.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_owner) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = found && (pick_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/seven_segment_display_arbiter.sv
// Round-robin, minimum-dwell arbiter sharing a 4-digit seven-segment display.
// Optional leading-zero blanking: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
module seven_segment_display_arbiter
    import seven_segment_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic                   clk_100_Mhz,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_value,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [15:0]            display_digits,
    output logic [DIGITS-1:0]      digit_blank,
    output logic                   display_valid,
    output logic                   switch_pulse
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

    arbiter_state_t   state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] last_owner_reg, last_owner_next;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic             first_reg, first_next;

    logic [NUM_REQ-1:0]  gnt_reg;
    logic [15:0]         display_digits_reg;
    logic [DIGITS-1:0]   digit_blank_reg;
    logic                display_valid_reg;
    logic                switch_pulse_reg;

    logic [15:0]         value_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  owner_onehot;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic [15:0]         owner_value;
    logic [DIGITS-1:0]   owner_blank;
    logic                owner_drop;
    logic                dwell_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign value_arr[gi]    = req_value[16*gi +: 16];
            assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    round_robin_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (req),
        .last_owner  (last_owner_reg),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    assign owner_value   = value_arr[owner_reg];
    assign owner_drop    = !req[owner_reg];
    assign dwell_expired = (dwell_reg == DWELL_MAX) && (|(req & ~owner_onehot));

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    assign owner_blank = invalid_mask(owner_value) | leading_zero_mask(owner_value);
`else
    assign owner_blank = invalid_mask(owner_value);
`endif

    always_ff @(posedge clk_100_Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            dwell_reg      <= '0;
            first_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            dwell_reg      <= dwell_next;
            first_reg      <= first_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        dwell_next      = dwell_reg;
        first_next      = 1'b0;
        case (state_reg)
            IDLE, HANDOFF: begin
                if (|pick_onehot) begin
                    state_next = GRANT;
                    owner_next = pick_idx;
                    dwell_next = '0;
                    first_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                // A drop colliding with expiry takes the same exit, so no priority is needed.
                if (owner_drop || dwell_expired) begin
                    state_next      = HANDOFF;
                    last_owner_next = owner_reg;
                end else if (dwell_reg != DWELL_MAX) begin
                    dwell_next = dwell_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs reflect the previous cycle's state, giving the one-cycle grant latency.
    always_ff @(posedge clk_100_Mhz or negedge reset_n) begin
        if (!reset_n) begin
            gnt_reg            <= '0;
            display_digits_reg <= 16'h0000;
            digit_blank_reg    <= BLANK_ALL;
            display_valid_reg  <= 1'b0;
            switch_pulse_reg   <= 1'b0;
        end else begin
            switch_pulse_reg <= first_reg;
            if (state_reg == GRANT) begin
                gnt_reg            <= owner_onehot;
                display_digits_reg <= owner_value;
                digit_blank_reg    <= owner_blank;
                display_valid_reg  <= 1'b1;
            end else begin
                gnt_reg            <= '0;
                digit_blank_reg    <= BLANK_ALL;
                display_valid_reg  <= 1'b0;
            end
        end
    end

    assign gnt            = gnt_reg;
    assign display_digits = display_digits_reg;
    assign digit_blank    = digit_blank_reg;
    assign display_valid  = display_valid_reg;
    assign switch_pulse   = switch_pulse_reg;

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// Directed bench for seven_segment_display_arbiter with NUM_REQ=4, DWELL_CYCLES=8.
module tb_seven_segment_display_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic             clk_100_Mhz = 1'b0;
    logic             reset_n     = 1'b0;
    logic [NR-1:0]    req         = '0;
    logic [16*NR-1:0] req_value   = '0;
    logic [NR-1:0]    gnt;
    logic [15:0]      display_digits;
    logic [3:0]       digit_blank;
    logic             display_valid;
    logic             switch_pulse;

    int checks = 0;
    int errors = 0;
    int pulses;
    int idx;
    int pos;
    logic [NR-1:0] exp_gnt;
    logic [3:0]    exp_blank_0042;
    logic [3:0]    exp_blank_0000;
    int            order [4] = '{0, 1, 3, 0};

    seven_segment_display_arbiter #(
        .NUM_REQ      (NR),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk_100_Mhz    (clk_100_Mhz),
        .reset_n        (reset_n),
        .req            (req),
        .req_value      (req_value),
        .gnt            (gnt),
        .display_digits (display_digits),
        .digit_blank    (digit_blank),
        .display_valid  (display_valid),
        .switch_pulse   (switch_pulse)
    );

    always #5 clk_100_Mhz = ~clk_100_Mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk_100_Mhz);
    endtask

    task automatic set_val(input int i, input logic [15:0] v);
        req_value[16*i +: 16] = v;
    endtask

    initial begin
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        exp_blank_0042 = 4'b1100;
        exp_blank_0000 = 4'b1110;
`else
        exp_blank_0042 = 4'b0000;
        exp_blank_0000 = 4'b0000;
`endif
        // Reset state
        repeat (3) tick();
        check("rst_gnt",    32'(gnt), 32'h0);
        check("rst_digits", 32'(display_digits), 32'h0);
        check("rst_blank",  32'(digit_blank), 32'hF);
        check("rst_valid",  32'(display_valid), 32'h0);
        check("rst_pulse",  32'(switch_pulse), 32'h0);
        reset_n = 1'b1;
        tick();

        // Single requester
        set_val(1, 16'h1234);
        req = 4'b0010;
        tick();
        check("single_latency_gnt", 32'(gnt), 32'h0);
        tick();
        check("single_gnt",    32'(gnt), 32'h2);
        check("single_pulse",  32'(switch_pulse), 32'h1);
        check("single_digits", 32'(display_digits), 32'h1234);
        check("single_valid",  32'(display_valid), 32'h1);
        check("single_blank",  32'(digit_blank), 32'h0);
        tick();
        check("single_pulse_off", 32'(switch_pulse), 32'h0);
        repeat (12) tick();
        check("single_hold_gnt", 32'(gnt), 32'h2);
        set_val(1, 16'h5678);
        tick();
        check("live_digits", 32'(display_digits), 32'h5678);
        set_val(1, 16'h1A3F);
        tick();
        check("invalid_blank", 32'(digit_blank), 32'h5);
        set_val(1, 16'h0042);
        tick();
        check("blank_0042", 32'(digit_blank), 32'(exp_blank_0042));
        set_val(1, 16'h0000);
        tick();
        check("blank_0000", 32'(digit_blank), 32'(exp_blank_0000));

        // Asynchronous reset mid-grant, no clock edge
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_gnt",   32'(gnt), 32'h0);
        check("async_rst_blank", 32'(digit_blank), 32'hF);
        check("async_rst_valid", 32'(display_valid), 32'h0);
        tick();
        req     = '0;
        reset_n = 1'b1;
        tick();

        // Contention: 0,1,3,0 with 8-cycle dwell and 1-cycle gap
        set_val(0, 16'h0001);
        set_val(1, 16'h0002);
        set_val(3, 16'h0003);
        req    = 4'b1011;
        pulses = 0;
        for (int k = 1; k <= 29; k++) begin
            tick();
            exp_gnt = '0;
            if (k >= 2) begin
                idx = (k - 2) / 9;
                pos = (k - 2) % 9;
                if (pos != 8) exp_gnt = NR'(1 << order[idx]);
            end
            if (switch_pulse) pulses++;
            check($sformatf("rr_gnt_k%0d", k), 32'(gnt), 32'(exp_gnt));
            if (k == 10) check("rr_gap_blank", 32'(digit_blank), 32'hF);
            if (k == 11) check("rr_owner1_digits", 32'(display_digits), 32'h0002);
        end
        check("rr_pulse_count", 32'(pulses), 32'd4);

        // Early release of owner 2 with requester 0 waiting
        reset_n = 1'b0;
        tick();
        req     = '0;
        reset_n = 1'b1;
        tick();
        set_val(2, 16'h0777);
        req = 4'b0100;
        tick();
        check("early_lat_gnt", 32'(gnt), 32'h0);
        req = 4'b0101;
        tick();
        check("early_gnt2", 32'(gnt), 32'h4);
        repeat (2) tick();
        req = 4'b0001;
        tick();
        check("early_still2", 32'(gnt), 32'h4);
        tick();
        check("early_handoff_gnt",    32'(gnt), 32'h0);
        check("early_handoff_blank",  32'(digit_blank), 32'hF);
        check("early_handoff_valid",  32'(display_valid), 32'h0);
        check("early_handoff_digits", 32'(display_digits), 32'h0777);
        tick();
        check("early_gnt0",   32'(gnt), 32'h1);
        check("early_pulse0", 32'(switch_pulse), 32'h1);

        // Owner drop coinciding with dwell expiry and a contender
        req = 4'b0101;
        repeat (6) tick();
        req    = 4'b0100;
        pulses = 0;
        for (int m = 14; m <= 18; m++) begin
            tick();
            if (switch_pulse) pulses++;
            if (m == 14) check("coll_still0", 32'(gnt), 32'h1);
            if (m == 15) begin
                check("coll_handoff_gnt",   32'(gnt), 32'h0);
                check("coll_handoff_blank", 32'(digit_blank), 32'hF);
            end
            if (m == 16) begin
                check("coll_gnt2",    32'(gnt), 32'h4);
                check("coll_digits2", 32'(display_digits), 32'h0777);
            end
            if (m == 18) check("coll_hold2", 32'(gnt), 32'h4);
        end
        check("coll_pulse_count", 32'(pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
